// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer AC datapath.
// Contents: opcode encodings, register-reference / IO bit indices in IR,
//           and the sequence-counter timing slots at which AC ops execute.
package mano_pkg;

   // IR[14:12] opcode values
   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_REG = 3'd7;

   // Register-reference bit positions within IR
   localparam int RR_CLA = 11;
   localparam int RR_CLE = 10;
   localparam int RR_CMA = 9;
   localparam int RR_CME = 8;
   localparam int RR_CIR = 7;
   localparam int RR_CIL = 6;
   localparam int RR_INC = 5;

   // IO bit position within IR
   localparam int IO_INP = 11;

   // Sequence-counter slots
   localparam logic [2:0] T_REG = 3'd3;
   localparam logic [2:0] T_MEM = 3'd5;

endpackage

// File: rtl/mano_ac_rr_alu.sv
// Combinational composer for register-reference micro-ops on {E,AC}.
// Ports: ac/e = current register values, rr = IR[11:5] (CLA..INC),
//        ac_nx/e_nx = result of applying every set bit in one pass.
module mano_ac_rr_alu
   import mano_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] ac,
   input  logic              e,
   input  logic [6:0]        rr,
   output logic [DATA_W-1:0] ac_nx,
   output logic              e_nx
);

   // rr is IR[11:5], so IR bit b sits at rr[b - RR_INC]
   logic cla, cle, cma, cme, cir, cil, inc;
   assign cla = rr[RR_CLA - RR_INC];
   assign cle = rr[RR_CLE - RR_INC];
   assign cma = rr[RR_CMA - RR_INC];
   assign cme = rr[RR_CME - RR_INC];
   assign cir = rr[RR_CIR - RR_INC];
   assign cil = rr[RR_CIL - RR_INC];
   assign inc = rr[RR_INC - RR_INC];

   logic [DATA_W-1:0] a;
   logic              b;

   always_comb begin
      a = ac;
      b = e;
      // stage 1: clears
      if (cla) a = '0;
      if (cle) b = 1'b0;
      // stage 2: complements
      if (cma) a = ~a;
      if (cme) b = ~b;
      // stage 3: rotate through E; both directions together cancel out
      if (cir && !cil) begin
         {a, b} = {b, a};
      end else if (cil && !cir) begin
         {b, a} = {a, b};
      end
      // stage 4: increment, carry out dropped, E untouched
      if (inc) a = a + DATA_W'(1);
      ac_nx = a;
      e_nx  = b;
   end

endmodule

// File: rtl/mano_ac_unit.sv
// Accumulator (AC) and extend flag (E) for the Mano basic computer.
// Ports: CLK/RST (sync, active-high), IR/T decode inputs, DR operand,
//        INPR input char; outputs AC, E and skip flags AC_ZERO/AC_NEG/E_ZERO.
// Optional: define MANO_AC_IO_EN to execute INP (IR=F800) at T3; otherwise
//           INPR is ignored and IO instructions leave AC/E alone.
module mano_ac_unit
   import mano_pkg::*;
#(
   parameter int              DATA_W = 16,
   parameter logic [DATA_W-1:0] AC_RST = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [15:0]       IR,
   input  logic [2:0]        T,
   input  logic [DATA_W-1:0] DR,
   input  logic [7:0]        INPR,
   output logic [DATA_W-1:0] AC,
   output logic              E,
   output logic              AC_ZERO,
   output logic              AC_NEG,
   output logic              E_ZERO
);

   logic [DATA_W-1:0] ac_q, ac_d;
   logic              e_q, e_d;

   logic [2:0] opcode;
   logic       ind;
   assign opcode = IR[14:12];
   assign ind    = IR[15];

   logic [DATA_W-1:0] rr_ac;
   logic              rr_e;

   mano_ac_rr_alu #(
      .DATA_W (DATA_W)
   ) u_rr_alu (
      .ac    (ac_q),
      .e     (e_q),
      .rr    (IR[11:5]),
      .ac_nx (rr_ac),
      .e_nx  (rr_e)
   );

   logic [DATA_W:0] add_sum;
   assign add_sum = {1'b0, ac_q} + {1'b0, DR};

   always_comb begin
      ac_d = ac_q;
      e_d  = e_q;
      if (opcode != OP_REG) begin
         // indirect bit plays no part here; operand already resolved in DR
         if (T == T_MEM) begin
            case (opcode)
               OP_AND:  ac_d = ac_q & DR;
               OP_ADD:  {e_d, ac_d} = add_sum;
               OP_LDA:  ac_d = DR;
               default: ;
            endcase
         end
      end else if (!ind) begin
         if (T == T_REG) begin
            ac_d = rr_ac;
            e_d  = rr_e;
         end
      end else begin
`ifdef MANO_AC_IO_EN
         if (T == T_REG && IR[IO_INP]) begin
            ac_d[7:0] = INPR;
         end
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ac_q <= AC_RST;
         e_q  <= 1'b0;
      end else begin
         ac_q <= ac_d;
         e_q  <= e_d;
      end
   end

   assign AC      = ac_q;
   assign E       = e_q;
   assign AC_ZERO = (ac_q == '0);
   assign AC_NEG  = ac_q[DATA_W-1];
   assign E_ZERO  = ~e_q;

   // skip/HLT bits are decoded by the control unit, not here
   logic unused_bits;
`ifdef MANO_AC_IO_EN
   assign unused_bits = ^IR[4:0];
`else
   assign unused_bits = ^{IR[4:0], INPR};
`endif

endmodule

// File: tb/tb_mano_ac_unit.sv
module tb_mano_ac_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 16-bit instance
   logic        rst;
   logic [15:0] ir;
   logic [2:0]  t;
   logic [15:0] dr;
   logic [7:0]  inpr;
   logic [15:0] ac;
   logic        e, ac_zero, ac_neg, e_zero;

   mano_ac_unit #(.DATA_W(16)) dut16 (
      .CLK(clk), .RST(rst), .IR(ir), .T(t), .DR(dr), .INPR(inpr),
      .AC(ac), .E(e), .AC_ZERO(ac_zero), .AC_NEG(ac_neg), .E_ZERO(e_zero)
   );

   // 8-bit instance
   logic        rst8;
   logic [15:0] ir8;
   logic [2:0]  t8;
   logic [7:0]  dr8;
   logic [7:0]  inpr8;
   logic [7:0]  ac8;
   logic        e8, ac_zero8, ac_neg8, e_zero8;

   mano_ac_unit #(.DATA_W(8)) dut8 (
      .CLK(clk), .RST(rst8), .IR(ir8), .T(t8), .DR(dr8), .INPR(inpr8),
      .AC(ac8), .E(e8), .AC_ZERO(ac_zero8), .AC_NEG(ac_neg8), .E_ZERO(e_zero8)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [15:0] ir;
      logic [2:0]  t;
      logic [15:0] dr;
      logic [15:0] ac;
      logic        e;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic r, input logic [15:0] i, input logic [2:0] tt,
                          input logic [15:0] d, input logic [15:0] a, input logic ee);
      vec_t v;
      v.rst = r; v.ir = i; v.t = tt; v.dr = d; v.ac = a; v.e = ee;
      vecs.push_back(v);
   endtask

   task automatic step8(input logic r, input logic [15:0] i, input logic [2:0] tt,
                        input logic [7:0] d, input logic [7:0] in);
      rst8 = r; ir8 = i; t8 = tt; dr8 = d; inpr8 = in;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_io;

   initial begin
      rst = 1'b0; ir = '0; t = '0; dr = '0; inpr = 8'h41;
      rst8 = 1'b0; ir8 = '0; t8 = '0; dr8 = '0; inpr8 = '0;

      //       rst   IR       T     DR        AC       E
      add_vec(1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0000, 1'b0); // reset
      add_vec(1'b0, 16'h2000, 3'd5, 16'h1234, 16'h1234, 1'b0); // LDA
      add_vec(1'b0, 16'h2000, 3'd4, 16'hFFFF, 16'h1234, 1'b0); // wrong T: hold
      add_vec(1'b0, 16'h2000, 3'd5, 16'hFFFF, 16'hFFFF, 1'b0); // LDA
      add_vec(1'b0, 16'h1000, 3'd5, 16'h0001, 16'h0000, 1'b1); // ADD carry
      add_vec(1'b0, 16'h2000, 3'd5, 16'hF0F0, 16'hF0F0, 1'b1); // LDA
      add_vec(1'b0, 16'h0000, 3'd5, 16'h0FF0, 16'h00F0, 1'b1); // AND
      add_vec(1'b0, 16'h8000, 3'd5, 16'h0F00, 16'h0000, 1'b1); // AND indirect
      add_vec(1'b0, 16'h3000, 3'd5, 16'hFFFF, 16'h0000, 1'b1); // opcode 3: hold
      add_vec(1'b0, 16'h7400, 3'd3, 16'h0000, 16'h0000, 1'b0); // CLE
      add_vec(1'b0, 16'h2000, 3'd5, 16'h0001, 16'h0001, 1'b0); // LDA
      add_vec(1'b0, 16'h7080, 3'd3, 16'h0000, 16'h0000, 1'b1); // CIR
      add_vec(1'b0, 16'h7040, 3'd3, 16'h0000, 16'h0001, 1'b0); // CIL
      add_vec(1'b0, 16'h2000, 3'd5, 16'h8000, 16'h8000, 1'b0); // LDA
      add_vec(1'b0, 16'h7040, 3'd3, 16'h0000, 16'h0000, 1'b1); // CIL msb->E
      add_vec(1'b0, 16'h70C0, 3'd3, 16'h0000, 16'h0000, 1'b1); // CIR+CIL no-op
      add_vec(1'b0, 16'h7A00, 3'd3, 16'h0000, 16'hFFFF, 1'b1); // CLA+CMA
      add_vec(1'b0, 16'h7020, 3'd3, 16'h0000, 16'h0000, 1'b1); // INC wraps, E kept
      add_vec(1'b0, 16'h2000, 3'd5, 16'h1234, 16'h1234, 1'b1); // LDA
      add_vec(1'b0, 16'h7C00, 3'd3, 16'h0000, 16'h0000, 1'b0); // CLA+CLE
      add_vec(1'b0, 16'h7100, 3'd3, 16'h0000, 16'h0000, 1'b1); // CME
      add_vec(1'b0, 16'h7200, 3'd5, 16'h0000, 16'h0000, 1'b1); // reg-ref at T5: none
      add_vec(1'b0, 16'hF020, 3'd3, 16'h0000, 16'h0000, 1'b1); // IO, no INP: none
      add_vec(1'b0, 16'h701F, 3'd3, 16'h0000, 16'h0000, 1'b1); // skip/HLT bits only
      add_vec(1'b1, 16'h2000, 3'd5, 16'h5555, 16'h0000, 1'b0); // reset beats LDA
      add_vec(1'b0, 16'h2000, 3'd5, 16'h8001, 16'h8001, 1'b0); // LDA
      add_vec(1'b0, 16'h1000, 3'd5, 16'h8001, 16'h0002, 1'b1); // ADD carry
      add_vec(1'b0, 16'h7380, 3'd3, 16'h0000, 16'h7FFE, 1'b1); // CMA+CME+CIR
      add_vec(1'b0, 16'h7060, 3'd3, 16'h0000, 16'hFFFE, 1'b0); // CIL+INC

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; ir = vecs[i].ir; t = vecs[i].t; dr = vecs[i].dr;
         @(posedge clk);
         #1;
         check("ac",      i, 32'(ac),      32'(vecs[i].ac));
         check("e",       i, 32'(e),       32'(vecs[i].e));
         check("ac_zero", i, 32'(ac_zero), 32'(vecs[i].ac == 16'h0000));
         check("ac_neg",  i, 32'(ac_neg),  32'(vecs[i].ac[15]));
         check("e_zero",  i, 32'(e_zero),  32'(!vecs[i].e));
      end

      // IO instruction on the 16-bit unit with INPR driven
      rst = 1'b0; ir = 16'hF800; t = 3'd3; dr = '0; inpr = 8'h41;
      @(posedge clk);
      #1;
`ifdef MANO_AC_IO_EN
      check("io16_ac", 0, 32'(ac), 32'h0000FF41);
`else
      check("io16_ac", 0, 32'(ac), 32'h0000FFFE);
`endif
      check("io16_e", 0, 32'(e), 32'h0);

      // DATA_W=8 sequence
      step8(1'b1, 16'h0000, 3'd0, 8'h00, 8'h00);
      check("w8_rst_ac", 0, 32'(ac8), 32'h00);
      check("w8_rst_zero", 0, 32'(ac_zero8), 32'h1);
      step8(1'b0, 16'h2000, 3'd5, 8'hF0, 8'h00);
      check("w8_lda", 0, 32'(ac8), 32'hF0);
      check("w8_neg", 0, 32'(ac_neg8), 32'h1);
      step8(1'b0, 16'h1000, 3'd5, 8'h20, 8'h00);
      check("w8_add_ac", 0, 32'(ac8), 32'h10);
      check("w8_add_e", 0, 32'(e8), 32'h1);
      check("w8_add_ezero", 0, 32'(e_zero8), 32'h0);
      step8(1'b0, 16'hF800, 3'd3, 8'h00, 8'h41);
`ifdef MANO_AC_IO_EN
      exp_io = 8'h41;
`else
      exp_io = 8'h10;
`endif
      check("w8_inp_ac", 0, 32'(ac8), 32'(exp_io));
      check("w8_inp_e", 0, 32'(e8), 32'h1);
      // CIR: E(1) enters msb, lsb goes to E
      step8(1'b0, 16'h7080, 3'd3, 8'h00, 8'h00);
      check("w8_cir_ac", 0, 32'(ac8), 32'({1'b1, exp_io[7:1]}));
      check("w8_cir_e", 0, 32'(e8), 32'(exp_io[0]));
      // INC wraps at 8 bits
      step8(1'b0, 16'h2000, 3'd5, 8'hFF, 8'h00);
      step8(1'b0, 16'h7020, 3'd3, 8'h00, 8'h00);
      check("w8_inc_ac", 0, 32'(ac8), 32'h00);
      check("w8_inc_e", 0, 32'(e8), 32'(exp_io[0]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
